// File: rtl/fixed_point_divider_pkg.sv
// Shared constants, geometry helpers and FSM encoding for the sequential fixed-point divider.
// Geometry depends on FXDIV_ROUND_EN, which adds one extra quotient bit for rounding.
package fixed_point_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } fxdiv_state_t;

    function automatic int calc_shift(input int wf1, input int wf2, input int wfo);
        return wf2 + wfo - wf1;
    endfunction

    function automatic int calc_nw(input int wi1, input int wf1, input int shift);
        return wi1 + wf1 + shift;
    endfunction

    function automatic int calc_qw(input int wio, input int wfo);
        return wio + wfo;
    endfunction

    // Saturation limits for the default 25-bit result format.
    localparam int                DEF_QW  = 25;
    localparam logic [DEF_QW-1:0] SAT_POS = {1'b0, {(DEF_QW-1){1'b1}}};
    localparam logic [DEF_QW-1:0] SAT_NEG = {1'b1, {(DEF_QW-1){1'b0}}};

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/busy/done handshake and operand/result bus of the fixed-point divider.
interface fixed_point_divider_if #(
    parameter int W1 = 23,
    parameter int W2 = 23,
    parameter int WO = 25
);
    logic          start;
    logic [W1-1:0] in1;
    logic [W2-1:0] in2;
    logic          busy;
    logic          done;
    logic          overFlow;
    logic          div_by_zero;
    logic [WO-1:0] FixedPoint_Div_Out;

    modport master (
        output start, in1, in2,
        input  busy, done, overFlow, div_by_zero, FixedPoint_Div_Out
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, overFlow, div_by_zero, FixedPoint_Div_Out
    );
endinterface

// File: rtl/fxdiv_sat_sign.sv
// FIX-stage combinational post-processing: optional rounding (FXDIV_ROUND_EN), sign apply, saturation.
// The compare is done in a width wide enough for both the magnitude and the result limits.
module fxdiv_sat_sign #(
    parameter int QBW = 43,
    parameter int QW  = 25
) (
    input  logic [QBW-1:0] quo,
    input  logic           neg,
    input  logic           neg1,
    input  logic           dz,
    output logic [QW-1:0]  res,
    output logic           ovf
);
    localparam int MW = QBW + 1;
    localparam int CW = ((MW > QW) ? MW : QW) + 1;

    localparam logic [CW-1:0] POS_LIM = (CW'(1) << (QW - 1)) - CW'(1);
    localparam logic [CW-1:0] NEG_LIM = CW'(1) << (QW - 1);
    localparam logic [QW-1:0] POS_SAT = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] NEG_SAT = {1'b1, {(QW-1){1'b0}}};

    logic [CW-1:0] mag_s;
    logic [CW-1:0] neg_mag_s;

`ifdef FXDIV_ROUND_EN
    // The extra LSB is the half bit: adding it rounds half away from zero.
    assign mag_s = CW'(quo >> 1) + CW'(quo[0]);
`else
    assign mag_s = CW'(quo);
`endif

    assign neg_mag_s = {CW{1'b0}} - mag_s;

    // Divide-by-zero saturates toward the dividend's sign; otherwise clamp the signed magnitude.
    always_comb begin
        res = {QW{1'b0}};
        ovf = 1'b0;
        if (dz) begin
            ovf = 1'b1;
            res = neg1 ? NEG_SAT : POS_SAT;
        end else if (neg) begin
            if (mag_s > NEG_LIM) begin
                ovf = 1'b1;
                res = NEG_SAT;
            end else begin
                res = neg_mag_s[QW-1:0];
            end
        end else begin
            if (mag_s > POS_LIM) begin
                ovf = 1'b1;
                res = POS_SAT;
            end else begin
                res = mag_s[QW-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring, one quotient bit per cycle, saturating result.
// Optional macro FXDIV_ROUND_EN adds one iteration and rounds half away from zero.
module fixed_point_divider
    import fixed_point_divider_pkg::*;
#(
    parameter int WI1 = 3,
    parameter int WF1 = 20,
    parameter int WI2 = 3,
    parameter int WF2 = 20,
    parameter int WIO = 5,
    parameter int WFO = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    fixed_point_divider_if.slave  bus
);
    localparam int W1    = WI1 + WF1;
    localparam int W2    = WI2 + WF2;
    localparam int SHIFT = calc_shift(WF1, WF2, WFO);
    localparam int NW    = calc_nw(WI1, WF1, SHIFT);
    localparam int QW    = calc_qw(WIO, WFO);
`ifdef FXDIV_ROUND_EN
    localparam int NIT   = NW + 1;
`else
    localparam int NIT   = NW;
`endif
    localparam int CNTW  = $clog2(NIT + 1);

    if (SHIFT < 0) begin : g_bad_shift
        $error("fixed_point_divider: WF2+WFO must be >= WF1");
    end

    fxdiv_state_t    state_r, state_next_s;
    logic [CNTW-1:0] cnt_r;
    logic [NIT-1:0]  num_r;
    logic [NIT-1:0]  quo_r;
    logic [W2-1:0]   rem_r;
    logic [W2-1:0]   den_r;
    logic            sign_r, neg1_r, dz_r;
    logic            busy_r, done_r, ovf_r, dz_out_r;
    logic [QW-1:0]   out_r;

    logic [W1-1:0]   mag1_s;
    logic [W2-1:0]   mag2_s;
    logic [NIT-1:0]  num_load_s;
    logic [W2:0]     rem_shift_s;
    logic [W2:0]     rem_diff_s;
    logic            ge_s;
    logic [QW-1:0]   sat_res_s;
    logic            sat_ovf_s;

    // Magnitudes are unsigned, so the most negative operand is representable.
    assign mag1_s = bus.in1[W1-1] ? (~bus.in1 + W1'(1)) : bus.in1;
    assign mag2_s = bus.in2[W2-1] ? (~bus.in2 + W2'(1)) : bus.in2;

    // Left-align |in1| in the numerator; trailing zeros supply SHIFT (and the round bit).
    always_comb begin
        num_load_s              = {NIT{1'b0}};
        num_load_s[NIT-1 -: W1] = mag1_s;
    end

    assign rem_shift_s = {rem_r, num_r[NIT-1]};
    assign rem_diff_s  = rem_shift_s - {1'b0, den_r};
    assign ge_s        = (rem_shift_s >= {1'b0, den_r});

    fxdiv_sat_sign #(
        .QBW (NIT),
        .QW  (QW)
    ) u_sat (
        .quo  (quo_r),
        .neg  (sign_r),
        .neg1 (neg1_r),
        .dz   (dz_r),
        .res  (sat_res_s),
        .ovf  (sat_ovf_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_DIV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_r == {CNTW{1'b0}}) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, restoring iterations and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CNTW{1'b0}};
            num_r    <= {NIT{1'b0}};
            quo_r    <= {NIT{1'b0}};
            rem_r    <= {W2{1'b0}};
            den_r    <= {W2{1'b0}};
            sign_r   <= 1'b0;
            neg1_r   <= 1'b0;
            dz_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            dz_out_r <= 1'b0;
            out_r    <= {QW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sign_r <= bus.in1[W1-1] ^ bus.in2[W2-1];
                        neg1_r <= bus.in1[W1-1];
                        dz_r   <= (bus.in2 == {W2{1'b0}});
                        num_r  <= num_load_s;
                        den_r  <= mag2_s;
                        rem_r  <= {W2{1'b0}};
                        quo_r  <= {NIT{1'b0}};
                        cnt_r  <= CNTW'(NIT - 1);
                        busy_r <= 1'b1;
                    end
                end
                ST_DIV: begin
                    rem_r <= ge_s ? rem_diff_s[W2-1:0] : rem_shift_s[W2-1:0];
                    quo_r <= {quo_r[NIT-2:0], ge_s};
                    num_r <= {num_r[NIT-2:0], 1'b0};
                    if (cnt_r != {CNTW{1'b0}}) begin
                        cnt_r <= cnt_r - CNTW'(1);
                    end
                end
                ST_FIX: begin
                    out_r    <= sat_res_s;
                    ovf_r    <= sat_ovf_s;
                    dz_out_r <= dz_r;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy               = busy_r;
    assign bus.done               = done_r;
    assign bus.overFlow           = ovf_r;
    assign bus.div_by_zero        = dz_out_r;
    assign bus.FixedPoint_Div_Out = out_r;

endmodule
